// File: rtl/prestage_sequencer_if.sv
// rtl/prestage_sequencer_if.sv - board-input / display-output bundle for prestage_sequencer
//
// Signals:
//   tick        pacing enable, one clk wide
//   btn_up      raw level, capture code
//   btn_down    raw level, clear to IDLE
//   btn_left    raw level, submit guess
//   btn_right   raw level, start/restart round
//   sw[7:0]     code / guess value
//   state[2:0]  IDLE=0 ARMED=1 RUN=2 WIN=3 LOSE=4
//   led[7:0]    registered LED pattern
//   disp_val    {timer, attempts, 1'b0, state}
//   done        WIN or LOSE
//   match       WIN
// master drives the board inputs; slave is the sequencer.
interface prestage_sequencer_if;
    logic        tick;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic [7:0]  sw;
    logic [2:0]  state;
    logic [7:0]  led;
    logic [15:0] disp_val;
    logic        done;
    logic        match;

    modport master (
        output tick, btn_up, btn_down, btn_left, btn_right, sw,
        input  state, led, disp_val, done, match
    );

    modport slave (
        input  tick, btn_up, btn_down, btn_left, btn_right, sw,
        output state, led, disp_val, done, match
    );
endinterface

// File: rtl/prestage_sequencer.sv
// rtl/prestage_sequencer.sv - game-round controller: button sync/edge detect, code capture, timed guessing round
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    prestage_sequencer_if.slave (buttons, sw, tick in; state, led, disp_val, done, match out)
// Parameters:
//   TIME_LIMIT  round length in ticks (1..255)
//   MAX_TRIES   wrong guesses allowed before loss (1..15)
module prestage_sequencer #(
    parameter logic [7:0] TIME_LIMIT = 8'd60,
    parameter logic [3:0] MAX_TRIES  = 4'd5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prestage_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // Button vector order: [3]=up [2]=down [1]=left [0]=right
    logic [3:0] w_btn_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_prev;
    logic [3:0] w_pulse;

    assign w_btn_raw = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
    assign w_pulse   = r_sync2 & ~r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
            r_prev  <= 4'd0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    state_t     r_state;
    logic [7:0] r_code;
    logic [7:0] r_timer;
    logic [3:0] r_attempts;
    logic [7:0] r_led;

    state_t     w_state_nxt;
    logic [7:0] w_code_nxt;
    logic [7:0] w_timer_nxt;
    logic [3:0] w_attempts_nxt;
    logic [7:0] w_led_nxt;
    logic       w_won;
    logic       w_lost;
    logic [3:0] w_att_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_code     <= 8'd0;
            r_timer    <= 8'd0;
            r_attempts <= 4'd0;
            r_led      <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_timer    <= w_timer_nxt;
            r_attempts <= w_attempts_nxt;
            r_led      <= w_led_nxt;
        end
    end

    // Only one button pulse acts per cycle (down > up > right > left); within
    // RUN the guess and the tick are folded together so both limits are seen.
    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_timer_nxt    = r_timer;
        w_attempts_nxt = r_attempts;
        w_led_nxt      = r_led;
        w_won          = 1'b0;
        w_lost         = 1'b0;
        w_att_inc      = r_attempts + 4'd1;

        if (w_pulse[2]) begin
            w_state_nxt    = ST_IDLE;
            w_code_nxt     = 8'd0;
            w_timer_nxt    = 8'd0;
            w_attempts_nxt = 4'd0;
            w_led_nxt      = 8'd0;
        end else if (w_pulse[3] && (r_state == ST_IDLE || r_state == ST_ARMED)) begin
            w_state_nxt = ST_ARMED;
            w_code_nxt  = bus.sw;
            w_led_nxt   = bus.sw;
        end else if (w_pulse[0] && (r_state == ST_ARMED || r_state == ST_WIN || r_state == ST_LOSE)) begin
            w_state_nxt    = ST_RUN;
            w_timer_nxt    = TIME_LIMIT;
            w_attempts_nxt = 4'd0;
            w_led_nxt      = 8'd0;
        end else if (r_state == ST_RUN) begin
            if (w_pulse[1]) begin
                if (bus.sw == r_code) begin
                    w_won     = 1'b1;
                    w_led_nxt = 8'hFF;
                end else begin
                    // Hint: a 1 marks a bit the guess already has right.
                    w_led_nxt      = ~(bus.sw ^ r_code);
                    w_attempts_nxt = w_att_inc;
                    if (w_att_inc == MAX_TRIES) begin
                        w_lost = 1'b1;
                    end
                end
            end
            if (bus.tick && r_timer != 8'd0) begin
                w_timer_nxt = r_timer - 8'd1;
                if (r_timer == 8'd1) begin
                    w_lost = 1'b1;
                end
            end
            // A correct guess beats a timer or tries expiry in the same cycle.
            if (w_won) begin
                w_state_nxt = ST_WIN;
            end else if (w_lost) begin
                w_state_nxt = ST_LOSE;
                w_led_nxt   = r_code;
            end
        end
    end

    assign bus.state    = r_state;
    assign bus.led      = r_led;
    assign bus.disp_val = {r_timer, r_attempts, 1'b0, r_state};
    assign bus.done     = (r_state == ST_WIN) || (r_state == ST_LOSE);
    assign bus.match    = (r_state == ST_WIN);

endmodule
